// File: rtl/quadrilatero_pkg.sv
// Common types for the quadrilatero matrix unit.
// rf_port_state_e: sequencing states of a register-file port master.
package quadrilatero_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } rf_port_state_e;
endpackage

// File: rtl/xif_pkg.sv
// Shared definitions for the core/coprocessor interface. Only the
// instruction id width is needed by the register-file port logic.
package xif_pkg;
    parameter int unsigned X_ID_WIDTH = 4;
endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with optional fall-through.
// Ports: clk_i/rst_ni (async active-low), flush_i clears contents,
//        push_i/data_i write side, pop_i/data_o read side,
//        full_o/empty_o status.
// Storage is reset to zero so data_o is 0 while the FIFO is empty after reset.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [ADDR_DEPTH-1:0]            rd_ptr_q, wr_ptr_q;
    logic [ADDR_DEPTH:0]              count_q;
    logic                             stored_empty, bypass, push_eff, pop_eff;

    assign stored_empty = (count_q == '0);
    assign full_o       = (count_q == (ADDR_DEPTH+1)'(DEPTH));
    // In fall-through mode an incoming word is visible while nothing is stored;
    // if it is popped in the same cycle it never touches the storage.
    assign bypass       = FALL_THROUGH && stored_empty && push_i && pop_i;
    assign empty_o      = stored_empty && !(FALL_THROUGH && push_i);
    assign data_o       = (FALL_THROUGH && stored_empty) ? data_i : mem_q[rd_ptr_q];
    assign push_eff     = push_i && !full_o && !bypass;
    assign pop_eff      = pop_i && !empty_o && !bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q <= (wr_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_eff)
                rd_ptr_q <= (rd_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            if (push_eff && !pop_eff)
                count_q <= count_q + 1'b1;
            else if (!push_eff && pop_eff)
                count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: rtl/quadrilatero_rf_port_master.sv
// Register-file port master: turns a single read or write command for one
// matrix register into N_ROWS row requests towards the register sequencer.
// Ports:
//   cmd_*           command handshake (we, register, instruction id)
//   raddr/rrowaddr/rready/rlast/rd_id, rdata/rvalid   sequencer read side
//   out_*           read-data stream (buffered, one row per beat, last flag)
//   waddr/wrowaddr/wdata/we/wlast/wr_id, wready       sequencer write side
//   in_*            write-data stream
//   busy            a command is in progress
module quadrilatero_rf_port_master
    import quadrilatero_pkg::*;
#(
    parameter int unsigned N_REGS    = 8,
    parameter int unsigned N_ROWS    = 4,
    parameter int unsigned RLEN      = 128,
    parameter int unsigned BUF_DEPTH = 2,
    localparam int unsigned RW  = $clog2(N_REGS),
    localparam int unsigned ROW = $clog2(N_ROWS),
    localparam int unsigned IDW = xif_pkg::X_ID_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [RW-1:0]   cmd_reg_i,
    input  logic [IDW-1:0]  cmd_id_i,
    output logic [RW-1:0]   raddr_o,
    output logic [ROW-1:0]  rrowaddr_o,
    output logic            rready_o,
    output logic            rlast_o,
    output logic [IDW-1:0]  rd_id_o,
    input  logic [RLEN-1:0] rdata_i,
    input  logic            rvalid_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [RLEN-1:0] out_data_o,
    output logic            out_last_o,
    output logic [RW-1:0]   waddr_o,
    output logic [ROW-1:0]  wrowaddr_o,
    output logic [RLEN-1:0] wdata_o,
    output logic            we_o,
    output logic            wlast_o,
    output logic [IDW-1:0]  wr_id_o,
    input  logic            wready_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [RLEN-1:0] in_data_i,
    output logic            busy_o
);
    rf_port_state_e state_q, state_d;
    logic [ROW-1:0] row_q, row_d;
    logic [RW-1:0]  reg_q, reg_d;
    logic [IDW-1:0] id_q, id_d;
    logic           last_row;
    logic           buf_full, buf_empty, buf_push, buf_pop;

    assign last_row = (row_q == ROW'(N_ROWS-1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            row_q   <= '0;
            reg_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            reg_q   <= reg_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        reg_d       = reg_q;
        id_d        = id_q;
        cmd_ready_o = 1'b0;
        rready_o    = 1'b0;
        rlast_o     = 1'b0;
        we_o        = 1'b0;
        wlast_o     = 1'b0;
        in_ready_o  = 1'b0;
        buf_push    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    reg_d   = cmd_reg_i;
                    id_d    = cmd_id_i;
                    row_d   = '0;
                    state_d = cmd_we_i ? WRITE : READ;
                end
            end
            READ: begin
                // Requesting only while there is room means a grant can always
                // be pushed, so the buffer never overflows.
                rready_o = !buf_full;
                rlast_o  = rready_o && last_row;
                if (rvalid_i && rready_o) begin
                    buf_push = 1'b1;
                    row_d    = row_q + 1'b1;   // N_ROWS is a power of two: wraps to 0
                    if (last_row) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (buf_empty) state_d = IDLE;
            end
            WRITE: begin
                we_o       = in_valid_i;
                wlast_o    = we_o && last_row;
                in_ready_o = wready_i && we_o;
                if (we_o && wready_i) begin
                    row_d = row_q + 1'b1;
                    if (last_row) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign raddr_o    = reg_q;
    assign waddr_o    = reg_q;
    assign rrowaddr_o = row_q;
    assign wrowaddr_o = row_q;
    assign rd_id_o    = id_q;
    assign wr_id_o    = id_q;
    // Write data is only presented while writing so idle outputs stay at 0.
    assign wdata_o    = (state_q == WRITE) ? in_data_i : '0;

    assign out_valid_o = !buf_empty;
    assign buf_pop     = out_valid_o && out_ready_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (RLEN + 1),
        .DEPTH        (BUF_DEPTH)
    ) i_rdata_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .data_i  ({rdata_i, last_row}),
        .push_i  (buf_push),
        .data_o  ({out_data_o, out_last_o}),
        .pop_i   (buf_pop)
    );
endmodule
